// File: rtl/slant_rx_frame_scheduler.sv
// Frame-level scheduler for the four-lane slant receive path: aligns lane frame starts,
// counts lines per lane and swaps the buffer banks during read-side vertical blanking.
module slant_rx_frame_scheduler #(
  parameter int          LINES     = 240,
  parameter int          ALIGN_WIN = 255,
  parameter logic [23:0] FRAME_TMO = 24'hFFFFFF,
  parameter int          LCW       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  frame_even,
  input  logic [3:0]  frame_odd,
  input  logic [3:0]  hsync,
  input  logic        hvsync,
  input  logic [1:0]  force_sel,
  input  logic [3:0]  lane_mask,
  output logic [3:0]  mem_cont,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        frame_parity,
  output logic        frame_ready,
  output logic [3:0]  lane_lost,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int AW = $clog2(ALIGN_WIN + 1);

  typedef enum logic [2:0] {IDLE, ALIGN, RECV, DONE, SWAP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      start, start_act, seen_upd, mismatch, full, cnt_en;
  logic [3:0]      active_q, seen, lost;
  logic            parity_q;
  logic [AW-1:0]   align_cnt;
  logic [23:0]     tmo_cnt;
  logic [LCW-1:0]  line_cnt [4];
  logic            recv_done, align_tmo, frame_tmo, swap_go;

  assign start     = frame_even | frame_odd;
  assign start_act = start & active_q;
  assign seen_upd  = seen | start_act;
  assign mismatch  = start_act & (frame_even ^ {4{parity_q}});
  assign align_tmo = (align_cnt == AW'(ALIGN_WIN));
  assign frame_tmo = (tmo_cnt == FRAME_TMO);
  assign swap_go   = (state == DONE) && !hvsync;
  assign rd_bank   = ~wr_bank;

  // A frame start on a lane pre-empts its hsync in the same cycle.
  always_comb begin
    full   = '0;
    cnt_en = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]   = (line_cnt[i] == LCW'(LINES));
      cnt_en[i] = active_q[i] & seen[i] & ~lost[i] & ~start[i] & hsync[i] &
                  (line_cnt[i] < LCW'(LINES));
    end
  end

  assign recv_done = &(full | ~(active_q & ~lost));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|(start & lane_mask)) state_nxt = ALIGN;
      ALIGN:   if ((seen_upd == active_q) || align_tmo) state_nxt = RECV;
      RECV:    if (recv_done || frame_tmo) state_nxt = DONE;
      DONE:    if (!hvsync) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    frame_ready = (state == SWAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= '0;
      seen      <= '0;
      lost      <= '0;
      parity_q  <= 1'b0;
      align_cnt <= '0;
      tmo_cnt   <= '0;
      for (int i = 0; i < 4; i++) line_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(start & lane_mask)) begin
            active_q  <= lane_mask;
            seen      <= start & lane_mask;
            parity_q  <= |(frame_even & lane_mask);
            align_cnt <= '0;
          end
        end
        ALIGN: begin
          align_cnt <= align_cnt + 1'b1;
          tmo_cnt   <= '0;
          seen      <= seen_upd;
          lost      <= lost | mismatch | (align_tmo ? (active_q & ~seen_upd) : 4'b0000);
        end
        RECV: begin
          tmo_cnt <= tmo_cnt + 24'd1;
          lost    <= lost | start_act | (frame_tmo ? (active_q & ~full) : 4'b0000);
        end
        SWAP: begin
          seen <= '0;
          lost <= '0;
          for (int i = 0; i < 4; i++) line_cnt[i] <= '0;
        end
        default: ;
      endcase
      if (state == ALIGN || state == RECV) begin
        for (int i = 0; i < 4; i++)
          if (cnt_en[i]) line_cnt[i] <= line_cnt[i] + 1'b1;
      end
    end
  end

  // Swap results become visible in the SWAP cycle itself, alongside frame_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank      <= 1'b0;
      mem_cont     <= '0;
      lane_lost    <= '0;
      frame_cnt    <= '0;
      frame_parity <= 1'b0;
    end else begin
      if (swap_go) begin
        wr_bank   <= ~wr_bank;
        mem_cont  <= active_q & ~lost;
        lane_lost <= active_q & lost;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (force_sel == 2'b11)      frame_parity <= 1'b1;
      else if (force_sel == 2'b10) frame_parity <= 1'b0;
      else if (swap_go)            frame_parity <= parity_q;
    end
  end

endmodule

// File: tb/tb_slant_rx_frame_scheduler.sv
// Self-checking bench for slant_rx_frame_scheduler: a frame-level reference model
// compared every cycle, plus literal expectations at each bank swap.
module tb_slant_rx_frame_scheduler;

  localparam int L_TB   = 4;
  localparam int AW_TB  = 8;
  localparam int TMO_TB = 100;

  localparam logic [2:0] M_IDLE = 3'd0, M_ALIGN = 3'd1, M_RECV = 3'd2,
                         M_DONE = 3'd3, M_SWAP = 3'd4;

  logic        clk, rst, hvsync;
  logic [3:0]  frame_even, frame_odd, hsync, lane_mask;
  logic [1:0]  force_sel;
  logic [3:0]  mem_cont, lane_lost;
  logic        wr_bank, rd_bank, frame_parity, frame_ready, busy;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  slant_rx_frame_scheduler #(
    .LINES(L_TB), .ALIGN_WIN(AW_TB), .FRAME_TMO(24'(TMO_TB)), .LCW(9)
  ) dut (
    .clk(clk), .rst(rst), .frame_even(frame_even), .frame_odd(frame_odd),
    .hsync(hsync), .hvsync(hvsync), .force_sel(force_sel), .lane_mask(lane_mask),
    .mem_cont(mem_cont), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_parity(frame_parity), .frame_ready(frame_ready), .lane_lost(lane_lost),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-level view of the receiver: which phase it is in, per-lane progress and results.
  typedef struct packed {
    logic [2:0]      phase;
    logic [3:0]      act;
    logic [3:0]      seen;
    logic [3:0]      lost;
    logic            even;
    logic [3:0][7:0] lines;
    logic [31:0]     elapsed;
    logic            wr;
    logic [3:0]      mem;
    logic [3:0]      ll;
    logic [15:0]     cnt;
    logic            fpar;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic r, logic [3:0] fe, logic [3:0] fo,
                                        logic [3:0] hs, logic hv, logic [1:0] fs,
                                        logic [3:0] msk);
    model_t     n;
    logic [3:0] st;
    bit         complete;
    n  = c;
    st = fe | fo;
    if (r) begin
      n = '0;
      return n;
    end
    if (fs == 2'b11)                       n.fpar = 1'b1;
    else if (fs == 2'b10)                  n.fpar = 1'b0;
    else if (c.phase == M_DONE && !hv)     n.fpar = c.even;
    case (c.phase)
      M_IDLE: begin
        if ((st & msk) != 4'b0000) begin
          n.phase   = M_ALIGN;
          n.act     = msk;
          n.seen    = st & msk;
          n.even    = ((fe & msk) != 4'b0000);
          n.lost    = '0;
          n.lines   = '0;
          n.elapsed = 0;
        end
      end
      M_ALIGN, M_RECV: begin
        for (int j = 0; j < 4; j++) begin
          if (c.act[j] && c.seen[j] && !c.lost[j] && !st[j] && hs[j] && c.lines[j] < L_TB)
            n.lines[j] = c.lines[j] + 8'd1;
          if (st[j] && c.act[j]) begin
            if (c.phase == M_ALIGN) begin
              n.seen[j] = 1'b1;
              if (fe[j] != c.even) n.lost[j] = 1'b1;
            end else begin
              n.lost[j] = 1'b1;
            end
          end
        end
        if (c.phase == M_ALIGN) begin
          if ((n.seen & c.act) == c.act) begin
            n.phase = M_RECV; n.elapsed = 0;
          end else if (c.elapsed == AW_TB) begin
            n.lost  = n.lost | (c.act & ~n.seen);
            n.phase = M_RECV; n.elapsed = 0;
          end else begin
            n.elapsed = c.elapsed + 1;
          end
        end else begin
          complete = 1'b1;
          for (int j = 0; j < 4; j++)
            if (c.act[j] && !c.lost[j] && c.lines[j] != L_TB) complete = 1'b0;
          if (complete) begin
            n.phase = M_DONE;
          end else if (c.elapsed == TMO_TB) begin
            for (int j = 0; j < 4; j++)
              if (c.act[j] && c.lines[j] < L_TB) n.lost[j] = 1'b1;
            n.phase = M_DONE;
          end else begin
            n.elapsed = c.elapsed + 1;
          end
        end
      end
      M_DONE: begin
        if (!hv) begin
          n.phase = M_SWAP;
          n.wr    = !c.wr;
          n.mem   = c.act & ~c.lost;
          n.ll    = c.act & c.lost;
          n.cnt   = c.cnt + 16'd1;
        end
      end
      default: begin
        n.phase = M_IDLE;
        n.seen  = '0;
        n.lost  = '0;
        n.lines = '0;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, frame_even, frame_odd, hsync, hvsync, force_sel, lane_mask);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mem_cont",     mem_cont,     m.mem);
      checkOutput("wr_bank",      wr_bank,      m.wr);
      checkOutput("rd_bank",      rd_bank,      !m.wr);
      checkOutput("frame_parity", frame_parity, m.fpar);
      checkOutput("frame_ready",  frame_ready,  (m.phase == M_SWAP));
      checkOutput("lane_lost",    lane_lost,    m.ll);
      checkOutput("frame_cnt",    frame_cnt,    m.cnt);
      checkOutput("busy",         busy,         (m.phase != M_IDLE));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] fe, input logic [3:0] fo, input logic [3:0] hs);
    frame_even = fe;
    frame_odd  = fo;
    hsync      = hs;
    @(posedge clk); #1;
    frame_even = '0;
    frame_odd  = '0;
    hsync      = '0;
  endtask

  task automatic sendLines(input logic [3:0] lanes, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(4'b0000, 4'b0000, lanes);
      idle(1);
    end
  endtask

  task automatic waitReady(input int budget, input string tag);
    int k = 0;
    while (frame_ready !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s frame_ready actual=%b expected=1 within %0d cycles", tag, frame_ready, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; hvsync = 1'b0; force_sel = 2'b00; lane_mask = 4'hF;
    frame_even = '0; frame_odd = '0; hsync = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    checkOutput("rst_wr_bank", wr_bank, 1'b0);
    checkOutput("rst_rd_bank", rd_bank, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_cnt", frame_cnt, 16'd0);
    rst = 1'b0;

    $display("[TB] parity override after reset");
    force_sel = 2'b11; idle(1);
    checkOutput("force_even", frame_parity, 1'b1);
    force_sel = 2'b10; idle(1);
    checkOutput("force_odd", frame_parity, 1'b0);
    force_sel = 2'b00;

    $display("[TB] four lanes aligned");
    applyStimulus(4'hF, 4'h0, 4'h0);
    sendLines(4'hF, L_TB);
    waitReady(20, "aligned");
    checkOutput("t1_mem_cont", mem_cont, 4'hF);
    checkOutput("t1_wr_bank", wr_bank, 1'b1);
    checkOutput("t1_parity", frame_parity, 1'b1);
    checkOutput("t1_frame_cnt", frame_cnt, 16'd1);
    idle(1);
    checkOutput("t1_ready_pulse", frame_ready, 1'b0);

    $display("[TB] lane 2 silent");
    applyStimulus(4'b1011, 4'h0, 4'h0);
    sendLines(4'b1011, L_TB);
    waitReady(30, "silent_lane");
    checkOutput("t2_lane_lost", lane_lost, 4'b0100);
    checkOutput("t2_mem_cont", mem_cont, 4'b1011);
    idle(1);

    $display("[TB] swap held off by vertical active");
    hvsync = 1'b1;
    applyStimulus(4'hF, 4'h0, 4'h0);
    sendLines(4'hF, L_TB);
    idle(3);
    applyStimulus(4'hF, 4'h0, 4'h0);
    idle(46);
    checkOutput("t3_busy_held", busy, 1'b1);
    checkOutput("t3_no_early_swap", frame_ready, 1'b0);
    hvsync = 1'b0;
    idle(1);
    checkOutput("t3_swap_after_blank", frame_ready, 1'b1);
    checkOutput("t3_frame_cnt", frame_cnt, 16'd3);
    idle(1);

    $display("[TB] lane 1 short, frame timeout");
    applyStimulus(4'hF, 4'h0, 4'h0);
    sendLines(4'hF, 3);
    sendLines(4'b1101, 1);
    waitReady(200, "timeout");
    checkOutput("t4_lane_lost", lane_lost, 4'b0010);
    checkOutput("t4_mem_cont", mem_cont, 4'b1101);
    idle(1);

    $display("[TB] mixed parity");
    lane_mask = 4'b1001;
    applyStimulus(4'b0000, 4'b0001, 4'h0);
    applyStimulus(4'b1000, 4'b0000, 4'h0);
    sendLines(4'b0001, L_TB);
    waitReady(20, "mixed_parity");
    checkOutput("t5_parity", frame_parity, 1'b0);
    checkOutput("t5_lane_lost", lane_lost, 4'b1000);
    checkOutput("t5_mem_cont", mem_cont, 4'b0001);
    force_sel = 2'b11; idle(1);
    checkOutput("t5_force_even", frame_parity, 1'b1);
    force_sel = 2'b00; idle(1);
    checkOutput("t5_parity_holds", frame_parity, 1'b1);
    lane_mask = 4'hF;

    $display("[TB] reset mid-frame");
    applyStimulus(4'hF, 4'h0, 4'h0);
    sendLines(4'hF, 2);
    rst = 1'b1; idle(1); rst = 1'b0;
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_frame_cnt", frame_cnt, 16'd0);
    checkOutput("t6_wr_bank", wr_bank, 1'b0);
    checkOutput("t6_mem_cont", mem_cont, 4'h0);
    applyStimulus(4'hF, 4'h0, 4'h0);
    sendLines(4'hF, L_TB);
    waitReady(20, "after_reset");
    checkOutput("t6_frame_cnt_after", frame_cnt, 16'd1);
    checkOutput("t6_mem_cont_after", mem_cont, 4'hF);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
